// File: rtl/wt_l15_responder.sv
// L1.5-side responder for the write-through cache's L1 <-> L1.5 interface.
// Services requests in accept order against a small 64-bit-word store; returns come after LATENCY cycles.

package wt_l15_pkg;
    localparam int L1_MAX_DATA_PACKETS = 4;
    localparam int L15_TID_WIDTH       = 3;

    localparam logic [4:0] L15_LOAD_RQ   = 5'b00000;
    localparam logic [4:0] L15_STORE_RQ  = 5'b00001;
    localparam logic [4:0] L15_ATOMIC_RQ = 5'b00110;
    localparam logic [4:0] L15_INT_RQ    = 5'b01001;
    localparam logic [4:0] L15_IMISS_RQ  = 5'b10000;

    localparam logic [3:0] L15_LOAD_RET  = 4'b0000;
    localparam logic [3:0] L15_IFILL_RET = 4'b0001;
    localparam logic [3:0] L15_ST_ACK    = 4'b0100;
    localparam logic [3:0] L15_ERR_RET   = 4'b1100;

    typedef struct packed {
        logic                     l15_val;
        logic                     l15_req_ack;
        logic [4:0]               l15_rqtype;
        logic                     l15_nc;
        logic [2:0]               l15_size;
        logic [L15_TID_WIDTH-1:0] l15_threadid;
        logic [39:0]              l15_address;
        logic [7:0]               l15_be;
        logic [63:0]              l15_data;
    } l15_req_t;

    typedef struct packed {
        logic                              l15_ack;
        logic                              l15_header_ack;
        logic                              l15_val;
        logic [3:0]                        l15_returntype;
        logic                              l15_l2miss;
        logic [1:0]                        l15_error;
        logic                              l15_noncacheable;
        logic                              l15_atomic;
        logic [L15_TID_WIDTH-1:0]          l15_threadid;
        logic                              l15_prefetch;
        logic                              l15_f4b;
        logic [64*L1_MAX_DATA_PACKETS-1:0] l15_data;
        logic                              l15_inval_icache_all_way;
        logic                              l15_inval_dcache_all_way;
        logic [11:0]                       l15_inval_address_15_4;
        logic                              l15_cross_invalidate;
        logic [1:0]                        l15_cross_invalidate_way;
        logic                              l15_inval_dcache_inval;
        logic                              l15_inval_icache_inval;
        logic [1:0]                        l15_inval_way;
        logic                              l15_blockinitstore;
    } l15_rtrn_t;
endpackage

// state     | meaning
// RET_IDLE  | return register empty, l15_val low
// RET_VALID | return register holds a packet, l15_val high until l15_req_ack
module wt_l15_responder
    import wt_l15_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 3,
    parameter int MEM_WORDS = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  l15_req_t                 req_i,
    output l15_rtrn_t                rtrn_o,
    output logic [$clog2(DEPTH):0]   outstanding_o
);
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;
    localparam int IW       = $clog2(MEM_WORDS);
    localparam int DW       = 64 * L1_MAX_DATA_PACKETS;
    localparam int AGEW     = $clog2(LATENCY) + 1;
    // Stored age already reflects the accept cycle, so the head pops LATENCY-1 cycles after accept.
    localparam int AGE_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam bit BYPASS   = (LATENCY == 1);

    typedef enum logic {RET_IDLE, RET_VALID} ret_state_t;

    logic [63:0]              mem [MEM_WORDS];

    logic [3:0]               fifo_rtype [DEPTH];
    logic [1:0]               fifo_err   [DEPTH];
    logic [L15_TID_WIDTH-1:0] fifo_tid   [DEPTH];
    logic                     fifo_nc    [DEPTH];
    logic [DW-1:0]            fifo_data  [DEPTH];
    logic [AGEW-1:0]          fifo_age   [DEPTH];

    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q;

    ret_state_t               state_q, state_d;
    logic [3:0]               ret_rtype_q;
    logic [1:0]               ret_err_q;
    logic [L15_TID_WIDTH-1:0] ret_tid_q;
    logic                     ret_nc_q;
    logic [DW-1:0]            ret_data_q;

    logic                     full, empty, accept, push, pop, bypass, load_ret;
    logic                     ret_val, ret_free, handshake, head_ready;
    logic [IW-1:0]            idx, line_base;
    logic [63:0]              rd_word;
    logic [DW-1:0]            rd_line;
    logic [3:0]               in_rtype;
    logic [1:0]               in_err;
    logic [DW-1:0]            in_data;
    logic                     unused_addr;

    assign unused_addr = ^{req_i.l15_address[39:IW+3], req_i.l15_address[2:0]};

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign accept     = req_i.l15_val & ~full & ~rst_i;
    assign ret_val    = (state_q == RET_VALID);
    assign handshake  = ret_val & req_i.l15_req_ack;
    assign ret_free   = ~ret_val | handshake;
    assign head_ready = ~empty & (fifo_age[rd_ptr_q] == '0);
    assign bypass     = BYPASS & accept & empty & ret_free;
    assign push       = accept & ~bypass;
    assign pop        = ret_free & head_ready;
    assign load_ret   = pop | bypass;

    assign idx       = req_i.l15_address[3 +: IW];
    assign line_base = idx & ~IW'(L1_MAX_DATA_PACKETS - 1);
    assign rd_word   = mem[idx];

    always_comb begin
        rd_line = '0;
        for (int k = 0; k < L1_MAX_DATA_PACKETS; k++) begin
            rd_line[64*k +: 64] = mem[line_base | IW'(k)];
        end
    end

    always_comb begin
        in_rtype = L15_ERR_RET;
        in_err   = 2'b11;
        in_data  = '0;
        case (req_i.l15_rqtype)
            L15_STORE_RQ: begin
                in_rtype = L15_ST_ACK;
                in_err   = 2'b00;
            end
            L15_LOAD_RQ: begin
                in_rtype = L15_LOAD_RET;
                in_err   = 2'b00;
                in_data  = (req_i.l15_size == 3'b111) ? rd_line : DW'(rd_word);
            end
            L15_IMISS_RQ: begin
                in_rtype = L15_IFILL_RET;
                in_err   = 2'b00;
                in_data  = rd_line;
            end
            default: ;
        endcase
    end

    // Backing store is deliberately left out of reset so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (accept && req_i.l15_rqtype == L15_STORE_RQ) begin
            for (int i = 0; i < 8; i++) begin
                if (req_i.l15_be[i]) mem[idx][8*i +: 8] <= req_i.l15_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (fifo_age[e] != '0) fifo_age[e] <= fifo_age[e] - AGEW'(1);
        end
        if (push) begin
            fifo_rtype[wr_ptr_q] <= in_rtype;
            fifo_err[wr_ptr_q]   <= in_err;
            fifo_tid[wr_ptr_q]   <= req_i.l15_threadid;
            fifo_nc[wr_ptr_q]    <= req_i.l15_nc;
            fifo_data[wr_ptr_q]  <= in_data;
            fifo_age[wr_ptr_q]   <= AGEW'(AGE_INIT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RET_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RET_IDLE:  if (load_ret) state_d = RET_VALID;
            RET_VALID: if (handshake && !load_ret) state_d = RET_IDLE;
            default:   state_d = RET_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ret_rtype_q <= '0;
            ret_err_q   <= '0;
            ret_tid_q   <= '0;
            ret_nc_q    <= 1'b0;
            ret_data_q  <= '0;
        end else if (load_ret) begin
            ret_rtype_q <= bypass ? in_rtype           : fifo_rtype[rd_ptr_q];
            ret_err_q   <= bypass ? in_err             : fifo_err[rd_ptr_q];
            ret_tid_q   <= bypass ? req_i.l15_threadid : fifo_tid[rd_ptr_q];
            ret_nc_q    <= bypass ? req_i.l15_nc       : fifo_nc[rd_ptr_q];
            ret_data_q  <= bypass ? in_data            : fifo_data[rd_ptr_q];
        end else if (handshake) begin
            ret_rtype_q <= '0;
            ret_err_q   <= '0;
            ret_tid_q   <= '0;
            ret_nc_q    <= 1'b0;
            ret_data_q  <= '0;
        end
    end

    always_comb begin
        rtrn_o                  = '0;
        rtrn_o.l15_ack          = accept;
        rtrn_o.l15_header_ack   = accept;
        rtrn_o.l15_val          = ret_val;
        rtrn_o.l15_returntype   = ret_rtype_q;
        rtrn_o.l15_error        = ret_err_q;
        rtrn_o.l15_threadid     = ret_tid_q;
        rtrn_o.l15_noncacheable = ret_nc_q;
        rtrn_o.l15_data         = ret_data_q;
    end

    assign outstanding_o = count_q;

endmodule

// File: tb/tb_wt_l15_responder.sv
// Directed bench for wt_l15_responder: table of single transactions plus latency,
// backpressure and mid-operation reset sequences.

module tb_wt_l15_responder;
    import wt_l15_pkg::*;

    logic      clk;
    logic      rst;
    l15_req_t  req;
    l15_rtrn_t rtrn;
    logic [2:0] outstanding;

    int n_chk  = 0;
    int n_fail = 0;

    wt_l15_responder #(.DEPTH(4), .LATENCY(3), .MEM_WORDS(256)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .rtrn_o        (rtrn),
        .outstanding_o (outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [4:0]   rq;
        logic [39:0]  addr;
        logic [7:0]   be;
        logic [2:0]   size;
        logic [63:0]  data;
        logic [2:0]   tid;
        logic         nc;
        logic [3:0]   ertype;
        logic [1:0]   eerr;
        logic [255:0] edata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    localparam logic [63:0] W0 = 64'h1111_0000_0000_0001;
    localparam logic [63:0] W1 = 64'h2222_0000_0000_0002;
    localparam logic [63:0] W2 = 64'h3333_0000_0000_0003;
    localparam logic [63:0] W3 = 64'h4444_0000_0000_0004;
    localparam logic [63:0] DR = 64'hDEAD_BEEF_CAFE_0080;

    function automatic vec_t mk(logic [4:0] rq, logic [39:0] addr, logic [7:0] be, logic [2:0] size,
                                logic [63:0] data, logic [2:0] tid, logic nc,
                                logic [3:0] ertype, logic [1:0] eerr, logic [255:0] edata);
        vec_t v;
        v.rq = rq; v.addr = addr; v.be = be; v.size = size; v.data = data;
        v.tid = tid; v.nc = nc; v.ertype = ertype; v.eerr = eerr; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rq, input logic [39:0] addr, input logic [7:0] be,
                         input logic [2:0] size, input logic [63:0] data, input logic [2:0] tid,
                         input logic nc);
        req.l15_val      = 1'b1;
        req.l15_rqtype   = rq;
        req.l15_address  = addr;
        req.l15_be       = be;
        req.l15_size     = size;
        req.l15_data     = data;
        req.l15_threadid = tid;
        req.l15_nc       = nc;
    endtask

    // One request for one cycle; ack is sampled mid-cycle.
    task automatic issue(input logic [4:0] rq, input logic [39:0] addr, input logic [7:0] be,
                         input logic [2:0] size, input logic [63:0] data, input logic [2:0] tid,
                         input logic nc, input logic exp_ack);
        drive(rq, addr, be, size, data, tid, nc);
        @(negedge clk);
        chk("l15_ack", 256'(rtrn.l15_ack), 256'(exp_ack));
        chk("l15_header_ack", 256'(rtrn.l15_header_ack), 256'(exp_ack));
        step();
        req.l15_val = 1'b0;
    endtask

    task automatic wait_ret(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rtrn.l15_val) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL ret_timeout: got l15_val=0 expected l15_val=1 within 40 cycles");
        end
    endtask

    initial begin
        bit ok;

        vecs[0]  = mk(L15_STORE_RQ, 40'h40, 8'hFF, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, L15_ST_ACK, 2'b00, '0);
        vecs[1]  = mk(L15_STORE_RQ, 40'h40, 8'h0F, 3'd3, 64'hAAAA_AAAA_1122_3344, 3'd2, 1'b0, L15_ST_ACK, 2'b00, '0);
        vecs[2]  = mk(L15_LOAD_RQ, 40'h40, 8'h00, 3'd3, 64'h0, 3'd3, 1'b0, L15_LOAD_RET, 2'b00, 256'h0000_0000_FFFF_FFFF_1122_3344 & 256'hFFFF_FFFF_FFFF_FFFF);
        vecs[3]  = mk(L15_STORE_RQ, 40'h1220, 8'hFF, 3'd3, W0, 3'd0, 1'b0, L15_ST_ACK, 2'b00, '0);
        vecs[4]  = mk(L15_STORE_RQ, 40'h1228, 8'hFF, 3'd3, W1, 3'd0, 1'b0, L15_ST_ACK, 2'b00, '0);
        vecs[5]  = mk(L15_STORE_RQ, 40'h1230, 8'hFF, 3'd3, W2, 3'd0, 1'b0, L15_ST_ACK, 2'b00, '0);
        vecs[6]  = mk(L15_STORE_RQ, 40'h1238, 8'hFF, 3'd3, W3, 3'd0, 1'b0, L15_ST_ACK, 2'b00, '0);
        vecs[7]  = mk(L15_IMISS_RQ, 40'h1234, 8'h00, 3'd0, 64'h0, 3'd4, 1'b0, L15_IFILL_RET, 2'b00, {W3, W2, W1, W0});
        vecs[8]  = mk(L15_LOAD_RQ, 40'h1230, 8'h00, 3'b111, 64'h0, 3'd6, 1'b1, L15_LOAD_RET, 2'b00, {W3, W2, W1, W0});
        vecs[9]  = mk(L15_LOAD_RQ, 40'h1230, 8'h00, 3'd3, 64'h0, 3'd2, 1'b0, L15_LOAD_RET, 2'b00, {192'h0, W2});
        vecs[10] = mk(L15_INT_RQ, 40'h40, 8'hFF, 3'd3, 64'h0, 3'd5, 1'b0, L15_ERR_RET, 2'b11, '0);
        vecs[11] = mk(L15_LOAD_RQ, 40'h40, 8'h00, 3'd3, 64'h0, 3'd5, 1'b0, L15_LOAD_RET, 2'b00, {192'h0, 64'hFFFF_FFFF_1122_3344});
        vecs[12] = mk(L15_STORE_RQ, 40'h48, 8'hFF, 3'd3, 64'h0123_4567_89AB_CDEF, 3'd1, 1'b0, L15_ST_ACK, 2'b00, '0);
        vecs[13] = mk(L15_STORE_RQ, 40'h48, 8'h80, 3'd0, 64'h55EE_EEEE_EEEE_EEEE, 3'd3, 1'b1, L15_ST_ACK, 2'b00, '0);
        vecs[14] = mk(L15_LOAD_RQ, 40'h48, 8'h00, 3'd2, 64'h0, 3'd7, 1'b0, L15_LOAD_RET, 2'b00, {192'h0, 64'h5523_4567_89AB_CDEF});

        // Reset: a request held during reset must not be acknowledged.
        req = '0;
        rst = 1'b1;
        step();
        step();
        drive(L15_STORE_RQ, 40'h40, 8'hFF, 3'd3, 64'h0, 3'd1, 1'b0);
        @(negedge clk);
        chk("rst_ack", 256'(rtrn.l15_ack), 256'(0));
        chk("rst_val", 256'(rtrn.l15_val), 256'(0));
        chk("rst_outstanding", 256'(outstanding), 256'(0));
        chk("rst_rtrn_all", 256'(rtrn), 256'(0));
        step();
        req.l15_val = 1'b0;
        rst = 1'b0;
        req.l15_req_ack = 1'b1;

        // Table of single transactions with return acknowledged immediately.
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].rq, vecs[i].addr, vecs[i].be, vecs[i].size, vecs[i].data,
                  vecs[i].tid, vecs[i].nc, 1'b1);
            wait_ret(ok);
            if (ok) begin
                chk($sformatf("v%0d_rtype", i), 256'(rtrn.l15_returntype), 256'(vecs[i].ertype));
                chk($sformatf("v%0d_error", i), 256'(rtrn.l15_error), 256'(vecs[i].eerr));
                chk($sformatf("v%0d_tid", i), 256'(rtrn.l15_threadid), 256'(vecs[i].tid));
                chk($sformatf("v%0d_nc", i), 256'(rtrn.l15_noncacheable), 256'(vecs[i].nc));
                chk($sformatf("v%0d_data", i), rtrn.l15_data, vecs[i].edata);
                chk($sformatf("v%0d_zero_fields", i),
                    256'({rtrn.l15_atomic, rtrn.l15_l2miss, rtrn.l15_f4b, rtrn.l15_prefetch,
                          rtrn.l15_inval_icache_all_way, rtrn.l15_inval_dcache_all_way,
                          rtrn.l15_inval_address_15_4, rtrn.l15_cross_invalidate,
                          rtrn.l15_cross_invalidate_way, rtrn.l15_inval_dcache_inval,
                          rtrn.l15_inval_icache_inval, rtrn.l15_inval_way,
                          rtrn.l15_blockinitstore}), 256'(0));
            end
            step();
        end

        // Latency: accept in cycle N, l15_val only in cycle N+3.
        issue(L15_LOAD_RQ, 40'h40, 8'h00, 3'd3, 64'h0, 3'd7, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_n1_val", 256'(rtrn.l15_val), 256'(0));
        chk("lat_n1_out", 256'(outstanding), 256'(1));
        step();
        @(negedge clk);
        chk("lat_n2_val", 256'(rtrn.l15_val), 256'(0));
        chk("lat_n2_out", 256'(outstanding), 256'(1));
        step();
        @(negedge clk);
        chk("lat_n3_val", 256'(rtrn.l15_val), 256'(1));
        chk("lat_n3_out", 256'(outstanding), 256'(0));
        chk("lat_n3_tid", 256'(rtrn.l15_threadid), 256'(7));
        step();
        @(negedge clk);
        chk("lat_n4_val", 256'(rtrn.l15_val), 256'(0));
        step();

        // Backpressure: 5 accepted (4 FIFO + return register), the 6th refused.
        req.l15_req_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            issue(L15_LOAD_RQ, 40'h40, 8'h00, 3'd3, 64'h0, 3'(k), 1'b0, (k < 5) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        chk("bp_outstanding", 256'(outstanding), 256'(4));
        chk("bp_val_held", 256'(rtrn.l15_val), 256'(1));
        chk("bp_head_tid", 256'(rtrn.l15_threadid), 256'(0));
        step();
        req.l15_req_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_ret%0d_val", k), 256'(rtrn.l15_val), 256'(1));
            chk($sformatf("bp_ret%0d_tid", k), 256'(rtrn.l15_threadid), 256'(k));
            chk($sformatf("bp_ret%0d_data", k), rtrn.l15_data, {192'h0, 64'hFFFF_FFFF_1122_3344});
            step();
        end
        @(negedge clk);
        chk("bp_drained_val", 256'(rtrn.l15_val), 256'(0));
        chk("bp_drained_out", 256'(outstanding), 256'(0));
        step();

        // Reset mid-operation: in-flight returns dropped, memory retained.
        issue(L15_STORE_RQ, 40'h80, 8'hFF, 3'd3, DR, 3'd0, 1'b0, 1'b1);
        wait_ret(ok);
        step();
        req.l15_req_ack = 1'b0;
        for (int k = 1; k < 5; k++) begin
            issue(L15_LOAD_RQ, 40'h80, 8'h00, 3'd3, 64'h0, 3'(k), 1'b1, 1'b1);
        end
        @(negedge clk);
        chk("mr_pre_val", 256'(rtrn.l15_val), 256'(1));
        chk("mr_pre_out", 256'(outstanding), 256'(3));
        step();
        rst = 1'b1;
        drive(L15_LOAD_RQ, 40'h80, 8'h00, 3'd3, 64'h0, 3'd6, 1'b0);
        @(negedge clk);
        chk("mr_rst_ack", 256'(rtrn.l15_ack), 256'(0));
        step();
        rst = 1'b0;
        req.l15_val = 1'b0;
        @(negedge clk);
        chk("mr_post_rtrn", 256'(rtrn), 256'(0));
        chk("mr_post_out", 256'(outstanding), 256'(0));
        step();
        @(negedge clk);
        chk("mr_post2_val", 256'(rtrn.l15_val), 256'(0));
        step();
        req.l15_req_ack = 1'b1;
        issue(L15_LOAD_RQ, 40'h80, 8'h00, 3'd3, 64'h0, 3'd2, 1'b0, 1'b1);
        wait_ret(ok);
        if (ok) begin
            chk("mr_load_data", rtrn.l15_data, {192'h0, DR});
            chk("mr_load_tid", 256'(rtrn.l15_threadid), 256'(2));
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
